// File: rtl/shared_timer_arb_pkg.sv
// Shared definitions for the shared countdown timer arbiter.
//   N_REQ_DEF : default number of requesters
//   W_DEF     : default timer/count width
//   state_e   : controller state (IDLE / RUN)
package shared_timer_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 26;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/shared_timer_arb_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index of the last winner; search starts at ptr+1
//   valid  : at least one request is set
//   winner : index of the first set request after ptr (wrapping)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    int idx;

    // Walk from the lowest priority (ptr+N_REQ == ptr) up to the highest
    // (ptr+1) so the last hit written is the highest-priority requester.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_timer_arb.sv
// Single countdown timer shared round-robin among N_REQ requesters.
//   c     : clock
//   reset : async active-low reset
//   req   : level request per requester
//   dly   : per-requester delay, requester i at [W*i +: W]
//   gnt   : one-hot grant (0 when idle)
//   done  : one-cycle completion pulse for the finished requester
//   busy  : high while a delay is running
//   count : remaining cycles of the current delay (0 when idle)
module shared_timer_arb
    import shared_timer_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic               c,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] dly,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [W-1:0]       count
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e                       state_q, state_d;
    logic   [IW-1:0]              ptr_q, ptr_d;
    logic   [IW-1:0]              win_q, win_d;
    logic   [W-1:0]               cnt_q, cnt_d;
    logic   [N_REQ-1:0]           gnt_q, gnt_d;
    logic   [N_REQ-1:0]           done_q, done_d;

    logic   [N_REQ-1:0][W-1:0]    dly_a;
    logic                         pick_vld;
    logic   [IW-1:0]              pick_idx;

    assign dly_a = dly;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_vld),
        .winner (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                cnt_d = '0;
                if (pick_vld) begin
                    state_d         = RUN;
                    ptr_d           = pick_idx;
                    win_d           = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    cnt_d           = dly_a[pick_idx];   // only sample point of dly
                end
            end
            RUN: begin
                if (!req[win_q]) begin
                    // abort wins over completion: no done pulse
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - W'(1);
                end else begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    done_d[win_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);   // requester 0 first after reset
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign count = cnt_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_shared_timer_arb.sv
// Testbench for shared_timer_arb: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model through
// an expectation queue drained by an independent monitor.
module tb_shared_timer_arb;

    localparam int N = 4;
    localparam int W = 26;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic         busy;
        logic [W-1:0] count;
    } exp_t;

    logic           c = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] dly = '0;
    logic [N-1:0]   gnt, done;
    logic           busy;
    logic [W-1:0]   count;

    shared_timer_arb #(.N_REQ(N), .W(W)) dut (
        .c(c), .reset(reset), .req(req), .dly(dly),
        .gnt(gnt), .done(done), .busy(busy), .count(count)
    );

    always #5 c = ~c;

    int nvec = 0;
    int nerr = 0;

    exp_t expq[$];

    // reference model: who owns the timer, how much is left, last winner
    int           m_owner = -1;
    logic [W-1:0] m_rem   = '0;
    int           m_ptr   = N - 1;

    // observation of DUT activity for directed checks
    logic [N-1:0] gseq[$];
    int           gcyc = 0;
    int           dcnt = 0;
    logic [N-1:0] prev_gnt = '0;

    task automatic model_step();
        exp_t e;
        bit   found;
        e = '0;
        found = 0;
        if (!reset) begin
            m_owner = -1; m_rem = '0; m_ptr = N - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!found && req[i]) begin
                    found = 1; m_owner = i; m_ptr = i; m_rem = dly[i*W +: W];
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1; m_rem = '0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
        end else begin
            e.done[m_owner] = 1'b1;
            m_owner = -1;
        end
        if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
        e.busy  = (m_owner >= 0);
        e.count = m_rem;
        expq.push_back(e);
    endtask

    // predict the next edge from the present inputs, then let the edge happen
    task automatic cyc();
        model_step();
        @(posedge c);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int want);
        nvec++;
        if (act != want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic clear_obs();
        gseq.delete();
        gcyc = 0;
        dcnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
    endtask

    task automatic set_dly(input int i, input int v);
        dly[i*W +: W] = W'(v);
    endtask

    // monitor: compares every DUT output cycle against the queued prediction
    initial begin
        exp_t me;
        forever begin
            @(posedge c);
            #1;
            if (expq.size() > 0) begin
                me = expq.pop_front();
                nvec++;
                if ({gnt, done, busy, count} !== me) begin
                    nerr++;
                    $display("FAIL outputs @%0t: got gnt=%b done=%b busy=%b count=%0d, want gnt=%b done=%b busy=%b count=%0d",
                             $time, gnt, done, busy, count, me.gnt, me.done, me.busy, me.count);
                end
                nvec++;
                if ($countones(gnt) > 1 || (gnt & done) != '0) begin
                    nerr++;
                    $display("FAIL invariant @%0t: gnt=%b done=%b, want onehot0 gnt disjoint from done",
                             $time, gnt, done);
                end
            end
            if (gnt != '0 && prev_gnt == '0) gseq.push_back(gnt);
            if (gnt != '0) gcyc++;
            if (done != '0) dcnt++;
            prev_gnt = gnt;
        end
    end

    initial begin
        logic [N-1:0] want_seq [5];
        want_seq[0] = 4'b0001; want_seq[1] = 4'b0010; want_seq[2] = 4'b0100;
        want_seq[3] = 4'b1000; want_seq[4] = 4'b0001;

        // reset held 100 ns, then a single 5-cycle delay on requester 0
        reset = 1'b0;
        repeat (10) cyc();
        reset = 1'b1;
        clear_obs();
        set_dly(0, 5); req = 4'b0001;
        repeat (7) cyc();
        req = '0;
        repeat (3) cyc();
        chk("d5_gnt_cycles", gcyc, 6);
        chk("d5_done_pulses", dcnt, 1);

        // all requesting, rotation order
        do_reset();
        clear_obs();
        for (int i = 0; i < N; i++) set_dly(i, 2);
        req = 4'b1111;
        repeat (22) cyc();
        req = '0;
        repeat (3) cyc();
        chk("rr_num_grants_ge5", (gseq.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < gseq.size(); i++)
            chk($sformatf("rr_grant%0d", i), int'(gseq[i]), int'(want_seq[i]));

        // zero delay
        do_reset();
        clear_obs();
        set_dly(1, 0); req = 4'b0010;
        repeat (2) cyc();
        req = '0;
        repeat (3) cyc();
        chk("d0_gnt_cycles", gcyc, 1);
        chk("d0_done_pulses", dcnt, 1);

        // abort at count 4
        do_reset();
        clear_obs();
        set_dly(2, 10); req = 4'b0100;
        for (int i = 0; i < 40 && !(m_owner == 2 && m_rem == 4); i++) cyc();
        chk("abort_reach_cnt4", int'(count), 4);
        req = '0;
        cyc();
        chk("abort_gnt", int'(gnt), 0);
        chk("abort_count", int'(count), 0);
        repeat (3) cyc();
        chk("abort_no_done", dcnt, 0);

        // asynchronous reset in the middle of a long delay
        do_reset();
        set_dly(0, 1000); req = 4'b0001;
        for (int i = 0; i < 1000 && !(m_owner == 0 && m_rem == 500); i++) cyc();
        chk("rst_reach_cnt500", int'(count), 500);
        clear_obs();
        reset = 1'b0;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        repeat (3) cyc();
        set_dly(0, 3); set_dly(3, 3);
        req = 4'b1001;
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst_first_grant", (gseq.size() > 0) ? int'(gseq[0]) : 0, 1);
        chk("rst_no_done", dcnt, 0);
        req = '0;
        repeat (2) cyc();

        // delay change after the grant must be ignored
        do_reset();
        clear_obs();
        set_dly(0, 3); req = 4'b0001;
        cyc();
        set_dly(0, 100);
        repeat (4) cyc();
        req = '0;
        repeat (3) cyc();
        chk("dlychg_gnt_cycles", gcyc, 4);
        chk("dlychg_done_pulses", dcnt, 1);

        // randomized traffic: sticky requests, churning delays, rare resets
        do_reset();
        for (int i = 0; i < N; i++) set_dly(i, $urandom_range(7));
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            if ($urandom_range(3) == 0)
                for (int i = 0; i < N; i++)
                    set_dly(i, ($urandom_range(9) == 0) ? $urandom_range(40) : $urandom_range(7));
            reset = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        reset = 1'b1;
        req = '0;
        repeat (3) cyc();

        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
